// File: rtl/mux_nx1_pipe.sv
// rtl/mux_nx1_pipe.sv - registered N:1 valid/ready mux; round-robin arbitration when MUX_NX1_RR_EN is defined
// Fixed select by sel; with MUX_NX1_RR_EN, mode=1 selects the first valid channel at or after ptr.
module mux_nx1_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(NUM_IN);

  logic [WIDTH-1:0]  r_out_data;
  logic [SEL_W-1:0]  r_out_sel;
  logic              r_out_valid;

  logic              w_load_ok;
  logic              w_cand_vld;
  logic [SEL_W-1:0]  w_cand;
  logic [NUM_IN-1:0] w_ready;
  logic              w_xfer;
  logic [WIDTH-1:0]  w_ch [NUM_IN];

  for (genvar g = 0; g < NUM_IN; g++) begin : g_ch
    assign w_ch[g] = in_data[g*WIDTH +: WIDTH];
  end

  // The register can accept a new word while its current word drains.
  assign w_load_ok = !r_out_valid || out_ready;

`ifdef MUX_NX1_RR_EN
  logic [SEL_W-1:0] r_ptr;
  logic             w_rr_found;
  logic [SEL_W-1:0] w_rr_idx;
  logic [SEL_W:0]   w_scan;

  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_scan     = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_scan = {1'b0, r_ptr} + (SEL_W+1)'(k);
      if (w_scan >= N_EXT) w_scan = w_scan - N_EXT;
      if (!w_rr_found && in_valid[w_scan[SEL_W-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_scan[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    w_cand_vld = 1'b0;
    w_cand     = sel;
    if (mode) begin
      w_cand_vld = w_rr_found;
      w_cand     = w_rr_idx;
    end else begin
      w_cand_vld = ({1'b0, sel} < N_EXT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_xfer && mode) begin
      r_ptr <= ({1'b0, w_cand} == N_EXT - 1'b1) ? '0 : w_cand + 1'b1;
    end
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;

  always_comb begin
    w_cand     = sel;
    w_cand_vld = ({1'b0, sel} < N_EXT);
  end
`endif

  always_comb begin
    w_ready = '0;
    if (w_cand_vld && w_load_ok) w_ready[w_cand] = 1'b1;
  end

  assign w_xfer = w_cand_vld && in_valid[w_cand] && w_load_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
    end else if (w_xfer) begin
      r_out_data  <= w_ch[w_cand];
      r_out_sel   <= w_cand;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_ready;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

endmodule
